// File: rtl/mod4_checker_pkg.sv
// Shared types and helpers for the mod-4 count stream checker.
package mod4_checker_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } state_t;

  // The counter wraps 3 -> 0, so plain 2-bit truncation is the sequence rule.
  function automatic logic [1:0] next_val(input logic [1:0] v);
    return v + 2'd1;
  endfunction

endpackage

// File: rtl/mod4_sequence_checker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mod4_sequence_checker.sv
// Lock/mismatch checker for a 2-bit mod-4 count stream with saturating error count.
module mod4_sequence_checker
  import mod4_checker_pkg::*;
#(
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 2,
  parameter int unsigned ERR_W        = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       value_in,
  input  logic             valid_in,
  input  logic             err_clear,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] error_count,
  output logic [1:0]       expected
);

  state_t           state, state_n;
  logic [CNT_W-1:0] good_cnt, good_cnt_n;
  logic [CNT_W-1:0] bad_cnt, bad_cnt_n;
  logic [1:0]       expected_n;
  logic             error_n;
  logic             match;
  logic [CNT_W-1:0] good_inc, bad_inc;

  assign match    = (value_in == expected);
  assign good_inc = good_cnt + 1'b1;
  assign bad_inc  = bad_cnt + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= HUNT;
      good_cnt <= '0;
      bad_cnt  <= '0;
      expected <= '0;
      error    <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_n;
      good_cnt <= good_cnt_n;
      bad_cnt  <= bad_cnt_n;
      expected <= expected_n;
      error    <= error_n;
      locked   <= (state_n == LOCKED);
    end
  end

  always_comb begin
    state_n    = state;
    good_cnt_n = good_cnt;
    bad_cnt_n  = bad_cnt;
    expected_n = expected;
    error_n    = 1'b0;
    if (valid_in) begin
      // Every valid sample resynchronises expected on the received value.
      expected_n = next_val(value_in);
      unique case (state)
        HUNT: begin
          good_cnt_n = CNT_W'(1);
          state_n    = CHECK;
        end
        CHECK: begin
          if (match) begin
            good_cnt_n = good_inc;
            if (good_inc == CNT_W'(LOCK_COUNT)) begin
              state_n   = LOCKED;
              bad_cnt_n = '0;
            end
          end else begin
            good_cnt_n = CNT_W'(1);
          end
        end
        LOCKED: begin
          if (match) begin
            bad_cnt_n = '0;
          end else begin
            error_n   = 1'b1;
            bad_cnt_n = bad_inc;
            if (bad_inc == CNT_W'(UNLOCK_COUNT)) begin
              state_n = HUNT;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (error_n),
    .clear (err_clear),
    .count (error_count)
  );

endmodule

// File: tb/tb_mod4_sequence_checker.sv
// Directed vector bench: default-width instance plus a 2-bit error counter instance.
module tb_mod4_sequence_checker;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] value_in;
  logic       valid_in;
  logic       err_clear;

  logic       locked8, error8;
  logic [7:0] count8;
  logic [1:0] exp8;
  logic       locked2, error2;
  logic [1:0] count2;
  logic [1:0] exp2;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  always #5 clock = ~clock;

  mod4_sequence_checker #(
    .LOCK_COUNT   (4),
    .UNLOCK_COUNT (2),
    .ERR_W        (8)
  ) dut8 (
    .clock       (clock),
    .reset       (reset),
    .value_in    (value_in),
    .valid_in    (valid_in),
    .err_clear   (err_clear),
    .locked      (locked8),
    .error       (error8),
    .error_count (count8),
    .expected    (exp8)
  );

  mod4_sequence_checker #(
    .LOCK_COUNT   (4),
    .UNLOCK_COUNT (2),
    .ERR_W        (2)
  ) dut2 (
    .clock       (clock),
    .reset       (reset),
    .value_in    (value_in),
    .valid_in    (valid_in),
    .err_clear   (err_clear),
    .locked      (locked2),
    .error       (error2),
    .error_count (count2),
    .expected    (exp2)
  );

  typedef struct {
    string      tag;
    logic       valid;
    logic [1:0] value;
    logic       clr;
    logic       locked;
    logic       error;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic [1:0] expv;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string tag, input logic valid, input logic [1:0] value,
                              input logic clr, input logic lk, input logic er,
                              input logic [7:0] c8, input logic [1:0] c2, input logic [1:0] ex);
    vec_t v;
    v.tag = tag; v.valid = valid; v.value = value; v.clr = clr;
    v.locked = lk; v.error = er; v.cnt8 = c8; v.cnt2 = c2; v.expv = ex;
    vecs.push_back(v);
  endfunction

  task automatic chk1(input string tag, input string field, input logic [7:0] act, input logic [7:0] want);
    if (act !== want) begin
      nmis++;
      $display("FAIL %s %s: got %0h want %0h", tag, field, act, want);
    end
  endtask

  task automatic check_all(input string tag, input logic lk, input logic er,
                           input logic [7:0] c8, input logic [1:0] c2, input logic [1:0] ex);
    nvec++;
    chk1(tag, "locked8",   {7'd0, locked8}, {7'd0, lk});
    chk1(tag, "error8",    {7'd0, error8},  {7'd0, er});
    chk1(tag, "count8",    count8,          c8);
    chk1(tag, "expected8", {6'd0, exp8},    {6'd0, ex});
    chk1(tag, "locked2",   {7'd0, locked2}, {7'd0, lk});
    chk1(tag, "error2",    {7'd0, error2},  {7'd0, er});
    chk1(tag, "count2",    {6'd0, count2},  {6'd0, c2});
    chk1(tag, "expected2", {6'd0, exp2},    {6'd0, ex});
  endtask

  task automatic apply(input string tag, input logic valid, input logic [1:0] value, input logic clr,
                       input logic lk, input logic er, input logic [7:0] c8,
                       input logic [1:0] c2, input logic [1:0] ex);
    @(negedge clock);
    valid_in  = valid;
    value_in  = value;
    err_clear = clr;
    @(posedge clock);
    #1;
    check_all(tag, lk, er, c8, c2, ex);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    valid_in = 1'b0;
    err_clear = 1'b0;
    #2;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    value_in = 2'd0;
    valid_in = 1'b0;
    err_clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_all("reset", 1'b0, 1'b0, 8'd0, 2'd0, 2'd0);
    @(negedge clock);
    reset = 1'b0;

    // Acquire on 0,1,2,3
    add("acq0", 1, 2'd0, 0, 0, 0, 8'd0, 2'd0, 2'd1);
    add("acq1", 1, 2'd1, 0, 0, 0, 8'd0, 2'd0, 2'd2);
    add("acq2", 1, 2'd2, 0, 0, 0, 8'd0, 2'd0, 2'd3);
    add("acq3", 1, 2'd3, 0, 1, 0, 8'd0, 2'd0, 2'd0);
    // Single glitch 0,1,3,0 keeps lock
    add("gl0",  1, 2'd0, 0, 1, 0, 8'd0, 2'd0, 2'd1);
    add("gl1",  1, 2'd1, 0, 1, 0, 8'd0, 2'd0, 2'd2);
    add("gl3",  1, 2'd3, 0, 1, 1, 8'd1, 2'd1, 2'd0);
    add("gl0b", 1, 2'd0, 0, 1, 0, 8'd1, 2'd1, 2'd1);
    add("idle", 0, 2'd3, 0, 1, 0, 8'd1, 2'd1, 2'd1);
    add("clr",  0, 2'd0, 1, 1, 0, 8'd0, 2'd0, 2'd1);
    // Two consecutive mismatches drop lock
    add("mm1",  1, 2'd3, 0, 1, 1, 8'd1, 2'd1, 2'd0);
    add("mm2",  1, 2'd3, 0, 0, 1, 8'd2, 2'd2, 2'd0);
    // 1,2,0,1,2,3: restart on 0, lock on 3, no errors
    add("rs1",  1, 2'd1, 0, 0, 0, 8'd2, 2'd2, 2'd2);
    add("rs2",  1, 2'd2, 0, 0, 0, 8'd2, 2'd2, 2'd3);
    add("rs0",  1, 2'd0, 0, 0, 0, 8'd2, 2'd2, 2'd1);
    add("rs1b", 1, 2'd1, 0, 0, 0, 8'd2, 2'd2, 2'd2);
    add("rs2b", 1, 2'd2, 0, 0, 0, 8'd2, 2'd2, 2'd3);
    add("rs3",  1, 2'd3, 0, 1, 0, 8'd2, 2'd2, 2'd0);
    // Saturation: alternate mismatch/match, then clear against a 6th mismatch
    add("sclr", 0, 2'd0, 1, 1, 0, 8'd0, 2'd0, 2'd0);
    add("sm1",  1, 2'd2, 0, 1, 1, 8'd1, 2'd1, 2'd3);
    add("sk1",  1, 2'd3, 0, 1, 0, 8'd1, 2'd1, 2'd0);
    add("sm2",  1, 2'd2, 0, 1, 1, 8'd2, 2'd2, 2'd3);
    add("sk2",  1, 2'd3, 0, 1, 0, 8'd2, 2'd2, 2'd0);
    add("sm3",  1, 2'd2, 0, 1, 1, 8'd3, 2'd3, 2'd3);
    add("sk3",  1, 2'd3, 0, 1, 0, 8'd3, 2'd3, 2'd0);
    add("sm4",  1, 2'd2, 0, 1, 1, 8'd4, 2'd3, 2'd3);
    add("sk4",  1, 2'd3, 0, 1, 0, 8'd4, 2'd3, 2'd0);
    add("sm5",  1, 2'd2, 0, 1, 1, 8'd5, 2'd3, 2'd3);
    add("sk5",  1, 2'd3, 0, 1, 0, 8'd5, 2'd3, 2'd0);
    add("sm6c", 1, 2'd2, 1, 1, 1, 8'd0, 2'd0, 2'd3);
    add("sk6",  1, 2'd3, 0, 1, 0, 8'd0, 2'd0, 2'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].tag, vecs[i].valid, vecs[i].value, vecs[i].clr,
            vecs[i].locked, vecs[i].error, vecs[i].cnt8, vecs[i].cnt2, vecs[i].expv);
    end

    // Valid gaps do not break the sequence
    do_reset();
    apply("gap0", 1, 2'd0, 0, 0, 0, 8'd0, 2'd0, 2'd1);
    apply("gap1", 1, 2'd1, 0, 0, 0, 8'd0, 2'd0, 2'd2);
    for (int i = 0; i < 3; i++) apply("gapidle", 0, 2'd0, 0, 0, 0, 8'd0, 2'd0, 2'd2);
    apply("gap2", 1, 2'd2, 0, 0, 0, 8'd0, 2'd0, 2'd3);
    apply("gap3", 1, 2'd3, 0, 1, 0, 8'd0, 2'd0, 2'd0);
    apply("gapm", 1, 2'd2, 0, 1, 1, 8'd1, 2'd1, 2'd3);

    // Asynchronous reset mid-stream, checked before any further clock edge
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 8'd0, 2'd0, 2'd0);
    @(negedge clock);
    reset = 1'b0;
    apply("post_rst", 1, 2'd2, 0, 0, 0, 8'd0, 2'd0, 2'd3);
    apply("post_rst2", 1, 2'd3, 0, 0, 0, 8'd0, 2'd0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
